// File: rtl/qpu_exu_moitf.sv
// ---------------------------------------------------------------------------
// qpu_exu_moitf -- outstanding measure instruction tracking FIFO
//
// Sits right after dispatch. Every dispatched measure instruction pushes its
// qubit list; results from the measurement unit pop entries in order. The OR
// of all pending qubit lists is published so dispatch can stall any consumer
// of FMR / measure results / qubit flags that touches a pending qubit.
//
// Optional build macro: QPU_MOITF_CHK_EN
//   defined   -> moitf_err flags (sticky until rst) a result whose qubit list
//                differs from the head entry, or a result arriving while empty
//   undefined -> no compare logic, moitf_err tied low
//
// Ports
//   clk, rst              core clock, async active-high reset
//   disp_moitf_ena        allocate an entry for the dispatched measure
//   disp_moitf_ready      an allocation can be accepted (~full)
//   disp_oitf_qfren       dispatch instruction uses the qubit flag
//   disp_oitf_qubitlist   qubit list of the dispatch instruction
//   oitfqf_match_dispql   dispatch list overlaps a pending measure
//   mres_valid            measurement result for the oldest entry
//   mres_qubitlist        qubit list returned with the result
//   mres_ready            result accepted (~empty)
//   moitf_empty/full/cnt  occupancy status
//   moitf_pend_qubits     OR of qubit lists of all valid entries
//   moitf_err             sticky protocol error (checker build only)
// ---------------------------------------------------------------------------
module qpu_exu_moitf #(
  parameter  int DEPTH     = 4,
  parameter  int QUBIT_NUM = 8,
  localparam int PTR_W     = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 disp_moitf_ena,
  output logic                 disp_moitf_ready,
  input  logic                 disp_oitf_qfren,
  input  logic [QUBIT_NUM-1:0] disp_oitf_qubitlist,
  output logic                 oitfqf_match_dispql,
  input  logic                 mres_valid,
  input  logic [QUBIT_NUM-1:0] mres_qubitlist,
  output logic                 mres_ready,
  output logic                 moitf_empty,
  output logic                 moitf_full,
  output logic [PTR_W:0]       moitf_cnt,
  output logic [QUBIT_NUM-1:0] moitf_pend_qubits,
  output logic                 moitf_err
);

  localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PTR_W:0]                      alc_ptr_q, alc_ptr_d;
  logic [PTR_W:0]                      ret_ptr_q, ret_ptr_d;
  logic [DEPTH-1:0]                    vld_q, vld_d;
  logic [DEPTH-1:0][QUBIT_NUM-1:0]     ent_q, ent_d;
  logic [DEPTH-1:0][QUBIT_NUM-1:0]     ent_msk;
  logic [PTR_W-1:0]                    alc_idx, ret_idx;
  logic                                alc_en, ret_en;

  assign alc_idx = alc_ptr_q[PTR_W-1:0];
  assign ret_idx = ret_ptr_q[PTR_W-1:0];

  assign moitf_empty = (alc_ptr_q == ret_ptr_q);
  assign moitf_full  = (alc_idx == ret_idx) && (alc_ptr_q[PTR_W] != ret_ptr_q[PTR_W]);
  assign moitf_cnt   = alc_ptr_q - ret_ptr_q;

  // No full bypass: a retire in the same cycle does not free a slot early.
  assign disp_moitf_ready = ~moitf_full;
  assign mres_ready       = ~moitf_empty;

  assign alc_en = disp_moitf_ena & ~moitf_full;
  assign ret_en = mres_valid & ~moitf_empty;

  // alc_idx == ret_idx only when empty or full, and then one of the two
  // enables is low, so set/clear never hit the same valid bit.
  always_comb begin
    alc_ptr_d = alc_ptr_q;
    ret_ptr_d = ret_ptr_q;
    vld_d     = vld_q;
    ent_d     = ent_q;
    if (alc_en) begin
      ent_d[alc_idx] = disp_oitf_qubitlist;
      vld_d[alc_idx] = 1'b1;
      alc_ptr_d      = alc_ptr_q + PTR_ONE;
    end
    if (ret_en) begin
      vld_d[ret_idx] = 1'b0;
      ret_ptr_d      = ret_ptr_q + PTR_ONE;
    end
  end

  // Pending list comes from registered state only, so the match output has
  // no combinational path from disp_moitf_ena or mres_valid.
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    assign ent_msk[i] = ent_q[i] & {QUBIT_NUM{vld_q[i]}};
  end

  always_comb begin
    moitf_pend_qubits = '0;
    for (int i = 0; i < DEPTH; i++) begin
      moitf_pend_qubits = moitf_pend_qubits | ent_msk[i];
    end
  end

  assign oitfqf_match_dispql = disp_oitf_qfren & (|(disp_oitf_qubitlist & moitf_pend_qubits));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alc_ptr_q <= '0;
      ret_ptr_q <= '0;
      vld_q     <= '0;
    end else begin
      alc_ptr_q <= alc_ptr_d;
      ret_ptr_q <= ret_ptr_d;
      vld_q     <= vld_d;
    end
  end

  // Entry payload is qualified by vld_q, so it needs no reset.
  always_ff @(posedge clk) begin
    ent_q <= ent_d;
  end

`ifdef QPU_MOITF_CHK_EN
  logic err_q, err_d;

  assign err_d = err_q
               | (ret_en & (mres_qubitlist != ent_q[ret_idx]))
               | (mres_valid & moitf_empty);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign moitf_err = err_q;
`else
  logic unused_mres;
  assign unused_mres = ^mres_qubitlist;
  assign moitf_err   = 1'b0;
`endif

endmodule

// File: tb/tb_qpu_exu_moitf.sv
module tb_qpu_exu_moitf;

  localparam int DEPTH = 4;
  localparam int QN    = 8;
`ifdef QPU_MOITF_CHK_EN
  localparam int CHK = 1;
`else
  localparam int CHK = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ena = 1'b0, qfren = 1'b0, mv = 1'b0;
  logic [QN-1:0] ql = '0, ml = '0;
  logic          ready, match, mres_ready, empty, full, err;
  logic [2:0]    cnt;
  logic [QN-1:0] pend;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  qpu_exu_moitf #(.DEPTH(DEPTH), .QUBIT_NUM(QN)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .disp_moitf_ena      (ena),
    .disp_moitf_ready    (ready),
    .disp_oitf_qfren     (qfren),
    .disp_oitf_qubitlist (ql),
    .oitfqf_match_dispql (match),
    .mres_valid          (mv),
    .mres_qubitlist      (ml),
    .mres_ready          (mres_ready),
    .moitf_empty         (empty),
    .moitf_full          (full),
    .moitf_cnt           (cnt),
    .moitf_pend_qubits   (pend),
    .moitf_err           (err)
  );

  typedef struct {
    logic          ena;
    logic          qfren;
    logic [QN-1:0] ql;
    logic          mv;
    logic [QN-1:0] ml;
    int            cnt;
    logic [QN-1:0] pend;
    logic          match;
    logic          cerr;   // error expected only in the checker build
  } vec_t;

  vec_t tbl[$];
  logic [QN-1:0] q[$];

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  // Occupancy flags are derived from the expected count.
  task automatic chk_state(input string tag, input int e_cnt, input logic [QN-1:0] e_pend,
                           input logic e_match, input int e_err);
    chk({tag, "_cnt"},   int'(cnt),        e_cnt);
    chk({tag, "_pend"},  int'(pend),       int'(e_pend));
    chk({tag, "_empty"}, int'(empty),      (e_cnt == 0) ? 1 : 0);
    chk({tag, "_full"},  int'(full),       (e_cnt == DEPTH) ? 1 : 0);
    chk({tag, "_ready"}, int'(ready),      (e_cnt != DEPTH) ? 1 : 0);
    chk({tag, "_mrdy"},  int'(mres_ready), (e_cnt != 0) ? 1 : 0);
    chk({tag, "_match"}, int'(match),      int'(e_match));
    chk({tag, "_err"},   int'(err),        e_err);
  endtask

  task automatic step(input logic a, input logic f, input logic [QN-1:0] l,
                      input logic v, input logic [QN-1:0] m);
    ena = a; qfren = f; ql = l; mv = v; ml = m;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [QN-1:0] q_or();
    logic [QN-1:0] r = '0;
    foreach (q[i]) r |= q[i];
    return r;
  endfunction

  initial begin
    //            ena qf  ql     mv  ml     cnt pend   m  cerr
    tbl.push_back('{0, 1, 8'hFF, 0, 8'h00, 0, 8'h00, 0, 0}); // idle
    tbl.push_back('{1, 0, 8'h01, 0, 8'h00, 1, 8'h01, 0, 0});
    tbl.push_back('{1, 0, 8'h06, 0, 8'h00, 2, 8'h07, 0, 0});
    tbl.push_back('{1, 0, 8'h10, 0, 8'h00, 3, 8'h17, 0, 0});
    tbl.push_back('{1, 0, 8'h80, 0, 8'h00, 4, 8'h97, 0, 0}); // full
    tbl.push_back('{0, 1, 8'h04, 0, 8'h00, 4, 8'h97, 1, 0});
    tbl.push_back('{1, 1, 8'h08, 0, 8'h00, 4, 8'h97, 0, 0}); // alloc while full ignored
    tbl.push_back('{0, 0, 8'h04, 0, 8'h00, 4, 8'h97, 0, 0});
    tbl.push_back('{0, 1, 8'h02, 1, 8'h01, 3, 8'h96, 1, 0});
    tbl.push_back('{0, 1, 8'h02, 1, 8'h06, 2, 8'h90, 0, 0});
    tbl.push_back('{0, 1, 8'h02, 1, 8'h10, 1, 8'h80, 0, 0});
    tbl.push_back('{0, 1, 8'h80, 1, 8'h80, 0, 8'h00, 0, 0}); // empty
    tbl.push_back('{0, 1, 8'hFF, 1, 8'h00, 0, 8'h00, 0, 1}); // retire while empty
    tbl.push_back('{1, 0, 8'h03, 0, 8'h00, 1, 8'h03, 0, 1});
    tbl.push_back('{1, 0, 8'h0C, 0, 8'h00, 2, 8'h0F, 0, 1});
    tbl.push_back('{1, 1, 8'h30, 1, 8'h03, 2, 8'h3C, 1, 1}); // alloc + retire

    // reset values, before any clock edge
    #3;
    chk_state("rst", 0, 8'h00, 1'b0, 0);
    #9 rst = 1'b0;

    foreach (tbl[i]) begin
      step(tbl[i].ena, tbl[i].qfren, tbl[i].ql, tbl[i].mv, tbl[i].ml);
      chk_state($sformatf("v%0d", i), tbl[i].cnt, tbl[i].pend, tbl[i].match,
                tbl[i].cerr ? CHK : 0);
    end

    // alloc/retire pairs walking both pointers past the wrap point
    q.push_back(8'h0C);
    q.push_back(8'h30);
    for (int k = 0; k < 10; k++) begin
      logic [QN-1:0] lst, hd;
      lst = 8'h01 << (k % 8);
      hd  = q.pop_front();
      q.push_back(lst);
      step(1'b1, 1'b0, lst, 1'b1, hd);
      chk_state($sformatf("pair%0d", k), q.size(), q_or(), 1'b0, CHK);
    end
    while (q.size() > 0) begin
      logic [QN-1:0] hd;
      hd = q.pop_front();
      step(1'b0, 1'b0, 8'h00, 1'b1, hd);
      chk_state("drain", q.size(), q_or(), 1'b0, CHK);
    end

    // async reset with three entries pending
    step(1'b1, 1'b0, 8'h01, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h02, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h04, 1'b0, 8'h00);
    ena = 1'b0; qfren = 1'b1; ql = 8'hFF;
    #1;
    chk_state("pre_arst", 3, 8'h07, 1'b1, CHK);
    #1 rst = 1'b1;
    #1;
    chk_state("arst", 0, 8'h00, 1'b0, 0);
    @(negedge clk) rst = 1'b0;

    // mismatched result list; error must stick until reset
    step(1'b1, 1'b0, 8'h01, 1'b0, 8'h00);
    chk_state("mm_alloc", 1, 8'h01, 1'b0, 0);
    step(1'b0, 1'b0, 8'h00, 1'b1, 8'h02);
    chk_state("mm_ret", 0, 8'h00, 1'b0, CHK);
    step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    chk_state("mm_hold1", 0, 8'h00, 1'b0, CHK);
    step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    chk_state("mm_hold2", 0, 8'h00, 1'b0, CHK);
    #2 rst = 1'b1;
    #1;
    chk("mm_clr_err", int'(err), 0);
    @(negedge clk) rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
